idex_pipe_reg: RTL and testbench

//  ID->EX pipeline register with a 2-entry skid buffer and valid/ready handshake.

---
 rtl/idex_pipe_reg.sv | 186 ++++++++++++++++++
 tb/tb_idex_pipe_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// idex_pipe_reg
//   ID->EX pipeline register with a two-entry skid buffer (OUT + SKID).
//
//   The OUT entry drives the EX-side outputs. When EX stalls while decode is
//   still sending, one more payload is parked in SKID. The upstream ready
//   signal is taken only from registered state (~skid_v), so ex2idex_ready_i
//   has no combinational path to idex2id_ready_o. A CU flush squashes both
//   entries. Ordering is strictly FIFO, and the register sustains one
//   transfer per cycle when EX is always ready.
//
//   Optional feature (compile-time macro IDEX_WB_BYPASS_EN):
//     When this macro is defined, a write-back strobe (wb2idex_*) patches
//     source1/source2 of the captured input and of every valid held entry
//     whose rs1/rs2 index matches a nonzero WB destination.
//     When it is undefined, the wb2idex_* ports are present but ignored.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   id2idex_valid_i/ready_o   decode-side handshake
//   id2idex_*_i               decode payload (sources, ins, pc, reg indices,
//                             imm_sb, imm_uj, wb_en, mem_en)
//   idex2ex_*_o               registered OUT payload presented to EX
//   idex2ex_valid_o           OUT entry valid
//   ex2idex_ready_i           EX consumes the OUT entry this cycle
//   cu2idex_flush_i           squash all entries, drop same-cycle input
//   wb2idex_wen_i/rd_i/data_i write-back bypass source
// ---------------------------------------------------------------------------
module idex_pipe_reg #(
  parameter int          DATA_W  = 32,
  parameter int          REG_AW  = 5,
  parameter logic [31:0] NOP_INS = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  // decode side
  input  logic              id2idex_valid_i,
  output logic              idex2id_ready_o,
  input  logic [DATA_W-1:0] id2idex_source1_i,
  input  logic [DATA_W-1:0] id2idex_source2_i,
  input  logic [DATA_W-1:0] id2idex_ins_i,
  input  logic [DATA_W-1:0] id2idex_addr_i,
  input  logic [REG_AW-1:0] id2idex_rd_addr_i,
  input  logic [REG_AW-1:0] id2idex_rs1_addr_i,
  input  logic [REG_AW-1:0] id2idex_rs2_addr_i,
  input  logic [DATA_W-1:0] id2idex_imm_sb_i,
  input  logic [DATA_W-1:0] id2idex_imm_uj_i,
  input  logic              id2idex_wb_en_i,
  input  logic              id2idex_mem_en_i,
  // execute side
  output logic [DATA_W-1:0] idex2ex_source1_o,
  output logic [DATA_W-1:0] idex2ex_source2_o,
  output logic [DATA_W-1:0] idex2ex_ins_o,
  output logic [DATA_W-1:0] idex2ex_addr_o,
  output logic [REG_AW-1:0] idex2ex_rd_addr_o,
  output logic [REG_AW-1:0] idex2ex_rs1_addr_o,
  output logic [REG_AW-1:0] idex2ex_rs2_addr_o,
  output logic [DATA_W-1:0] idex2ex_imm_sb_o,
  output logic [DATA_W-1:0] idex2ex_imm_uj_o,
  output logic              idex2ex_wb_en_o,
  output logic              idex2ex_mem_en_o,
  output logic              idex2ex_valid_o,
  input  logic              ex2idex_ready_i,
  // control / write-back
  input  logic              cu2idex_flush_i,
  input  logic              wb2idex_wen_i,
  input  logic [REG_AW-1:0] wb2idex_rd_i,
  input  logic [DATA_W-1:0] wb2idex_data_i
);

  typedef struct packed {
    logic [DATA_W-1:0] source1;
    logic [DATA_W-1:0] source2;
    logic [DATA_W-1:0] ins;
    logic [DATA_W-1:0] addr;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] imm_sb;
    logic [DATA_W-1:0] imm_uj;
    logic              wb_en;
    logic              mem_en;
  } payload_t;

  // Payload of an empty/flushed register: a NOP with side effects disabled.
  localparam payload_t EMPTY_PAYLOAD = '{
    source1:  '0, source2: '0, ins: DATA_W'(NOP_INS), addr: '0,
    rd_addr:  '0, rs1_addr: '0, rs2_addr: '0,
    imm_sb:   '0, imm_uj:  '0, wb_en: 1'b0, mem_en: 1'b0
  };

  payload_t out_reg;
  payload_t skid_reg;
  logic     out_v_reg;
  logic     skid_v_reg;

  payload_t in_payload;
  payload_t in_byp;
  payload_t out_byp;
  payload_t skid_byp;
  logic     accept;
  logic     pop;

  assign in_payload = '{
    source1:  id2idex_source1_i,  source2:  id2idex_source2_i,
    ins:      id2idex_ins_i,      addr:     id2idex_addr_i,
    rd_addr:  id2idex_rd_addr_i,  rs1_addr: id2idex_rs1_addr_i,
    rs2_addr: id2idex_rs2_addr_i, imm_sb:   id2idex_imm_sb_i,
    imm_uj:   id2idex_imm_uj_i,   wb_en:    id2idex_wb_en_i,
    mem_en:   id2idex_mem_en_i
  };

`ifdef IDEX_WB_BYPASS_EN
  // Patch an entry's operands with the write-back value when its source
  // indices match a nonzero WB destination (x0 is never forwarded).
  function automatic payload_t wb_bypass(input payload_t p);
    payload_t r;
    r = p;
    if (wb2idex_wen_i && (wb2idex_rd_i != '0)) begin
      if (wb2idex_rd_i == p.rs1_addr) r.source1 = wb2idex_data_i;
      if (wb2idex_rd_i == p.rs2_addr) r.source2 = wb2idex_data_i;
    end
    return r;
  endfunction

  assign in_byp   = wb_bypass(in_payload);
  assign out_byp  = out_v_reg  ? wb_bypass(out_reg)  : out_reg;
  assign skid_byp = skid_v_reg ? wb_bypass(skid_reg) : skid_reg;
`else
  // Without the bypass, sources are held exactly as captured.
  logic unused_wb;
  assign unused_wb = ^{wb2idex_wen_i, wb2idex_rd_i, wb2idex_data_i};
  assign in_byp    = in_payload;
  assign out_byp   = out_reg;
  assign skid_byp  = skid_reg;
`endif

  // Ready depends only on registered state: the SKID slot must be free.
  assign idex2id_ready_o = ~skid_v_reg;
  assign accept          = id2idex_valid_i & ~skid_v_reg;
  assign pop             = out_v_reg & ex2idex_ready_i;

  always_ff @(posedge clk) begin
    if (rst || cu2idex_flush_i) begin
      out_v_reg  <= 1'b0;
      skid_v_reg <= 1'b0;
      out_reg    <= EMPTY_PAYLOAD;
      skid_reg   <= EMPTY_PAYLOAD;
    end else begin
      // Default: held entries keep their (possibly bypassed) contents.
      out_reg  <= out_byp;
      skid_reg <= skid_byp;
      if (skid_v_reg && pop) begin
        // SKID advances to OUT; accept is impossible since ready was low.
        out_reg    <= skid_byp;
        skid_v_reg <= 1'b0;
      end else if (accept && (!out_v_reg || pop)) begin
        out_reg   <= in_byp;
        out_v_reg <= 1'b1;
      end else if (accept && out_v_reg && !pop) begin
        skid_reg   <= in_byp;
        skid_v_reg <= 1'b1;
      end else if (pop && !accept) begin
        // Drained: disable side effects so an idle OUT is harmless.
        out_v_reg      <= 1'b0;
        out_reg.wb_en  <= 1'b0;
        out_reg.mem_en <= 1'b0;
      end
    end
  end

  assign idex2ex_valid_o    = out_v_reg;
  assign idex2ex_source1_o  = out_reg.source1;
  assign idex2ex_source2_o  = out_reg.source2;
  assign idex2ex_ins_o      = out_reg.ins;
  assign idex2ex_addr_o     = out_reg.addr;
  assign idex2ex_rd_addr_o  = out_reg.rd_addr;
  assign idex2ex_rs1_addr_o = out_reg.rs1_addr;
  assign idex2ex_rs2_addr_o = out_reg.rs2_addr;
  assign idex2ex_imm_sb_o   = out_reg.imm_sb;
  assign idex2ex_imm_uj_o   = out_reg.imm_uj;
  // Side-effect enables are masked by valid so they are never seen idle.
  assign idex2ex_wb_en_o    = out_reg.wb_en  & out_v_reg;
  assign idex2ex_mem_en_o   = out_reg.mem_en & out_v_reg;

endmodule

// File: tb/tb_idex_pipe_reg.sv
module tb_idex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] src1_i, src2_i, ins_i, addr_i, imm_sb_i, imm_uj_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic        wb_en_i, mem_en_i;
  logic [31:0] src1_o, src2_o, ins_o, addr_o, imm_sb_o, imm_uj_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        wb_en_o, mem_en_o, valid_o;
  logic        ready_i;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  idex_pipe_reg dut (
    .clk(clk), .rst(rst),
    .id2idex_valid_i(valid_i), .idex2id_ready_o(ready_o),
    .id2idex_source1_i(src1_i), .id2idex_source2_i(src2_i),
    .id2idex_ins_i(ins_i), .id2idex_addr_i(addr_i),
    .id2idex_rd_addr_i(rd_i), .id2idex_rs1_addr_i(rs1_i),
    .id2idex_rs2_addr_i(rs2_i), .id2idex_imm_sb_i(imm_sb_i),
    .id2idex_imm_uj_i(imm_uj_i), .id2idex_wb_en_i(wb_en_i),
    .id2idex_mem_en_i(mem_en_i),
    .idex2ex_source1_o(src1_o), .idex2ex_source2_o(src2_o),
    .idex2ex_ins_o(ins_o), .idex2ex_addr_o(addr_o),
    .idex2ex_rd_addr_o(rd_o), .idex2ex_rs1_addr_o(rs1_o),
    .idex2ex_rs2_addr_o(rs2_o), .idex2ex_imm_sb_o(imm_sb_o),
    .idex2ex_imm_uj_o(imm_uj_o), .idex2ex_wb_en_o(wb_en_o),
    .idex2ex_mem_en_o(mem_en_o), .idex2ex_valid_o(valid_o),
    .ex2idex_ready_i(ready_i), .cu2idex_flush_i(flush),
    .wb2idex_wen_i(wb_wen), .wb2idex_rd_i(wb_rd), .wb2idex_data_i(wb_data)
  );

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-16s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a payload whose fields are derived from ins for easy tracking.
  task automatic send(input logic [31:0] ins);
    valid_i  = 1'b1;
    ins_i    = ins;
    src1_i   = ins + 32'h100;
    src2_i   = ins + 32'h200;
    addr_i   = ins << 2;
    wb_en_i  = 1'b1;
    mem_en_i = 1'b1;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush = 1'b0;
    src1_i = '0; src2_i = '0; ins_i = '0; addr_i = '0;
    imm_sb_i = '0; imm_uj_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    wb_en_i = 1'b0; mem_en_i = 1'b0;
    wb_wen = 1'b0; wb_rd = '0; wb_data = '0;

    // 1: reset
    tick(); tick();
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    check("rst_ins",   ins_o, 32'h13);
    check("rst_wb_en", {31'b0, wb_en_o}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en_o}, 32'd0);
    check("rst_src1",  src1_o, 32'd0);
    rst = 1'b0;

    // 2: stream with EX always ready, one-cycle latency
    ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send(k);
      tick();
      check("stream_valid", {31'b0, valid_o}, 32'd1);
      check("stream_ins",   ins_o, k);
      check("stream_src1",  src1_o, k + 32'h100);
      check("stream_ready", {31'b0, ready_o}, 32'd1);
    end
    valid_i = 1'b0;
    tick();
    check("drain_valid", {31'b0, valid_o}, 32'd0);
    check("drain_wb_en", {31'b0, wb_en_o}, 32'd0);

    // 3: back-pressure, A then B through SKID
    ready_i = 1'b0;
    send(32'hA); tick();
    check("bp_a_ins",   ins_o, 32'hA);
    check("bp_a_ready", {31'b0, ready_o}, 32'd1);
    send(32'hB); tick();
    check("bp_b_ready", {31'b0, ready_o}, 32'd0);
    check("bp_hold_ins", ins_o, 32'hA);
    valid_i = 1'b0; tick();
    check("bp_stable",  ins_o, 32'hA);
    check("bp_stable_v", {31'b0, valid_o}, 32'd1);
    ready_i = 1'b1; tick();
    check("bp_b_out",   ins_o, 32'hB);
    check("bp_b_src2",  src2_o, 32'h20B);
    check("bp_ready_up", {31'b0, ready_o}, 32'd1);
    check("bp_b_valid", {31'b0, valid_o}, 32'd1);
    tick();
    check("bp_empty",   {31'b0, valid_o}, 32'd0);

    // 4: flush with both entries full and a same-cycle input
    ready_i = 1'b0;
    send(32'hA); tick();
    send(32'hB); tick();
    check("fl_full",    {31'b0, ready_o}, 32'd0);
    send(32'hC); flush = 1'b1; tick();
    check("fl_valid",   {31'b0, valid_o}, 32'd0);
    check("fl_ins",     ins_o, 32'h13);
    check("fl_ready",   {31'b0, ready_o}, 32'd1);
    check("fl_wb_en",   {31'b0, wb_en_o}, 32'd0);
    flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1; tick();
    check("fl_no_c",    {31'b0, valid_o}, 32'd0);

    // 5/6: write-back bypass on a held OUT entry
    ready_i = 1'b0;
    send(32'h55); src1_i = 32'd0; src2_i = 32'd0; rs1_i = 5'd5; rs2_i = 5'd7;
    tick();
    valid_i = 1'b0;
    check("byp_init",   src1_o, 32'd0);
    wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD; tick();
`ifdef IDEX_WB_BYPASS_EN
    check("byp_rs1",    src1_o, 32'hDEAD);
`else
    check("byp_rs1",    src1_o, 32'd0);
`endif
    check("byp_rs2_keep", src2_o, 32'd0);
    wb_rd = 5'd0; wb_data = 32'hBEEF; tick();
`ifdef IDEX_WB_BYPASS_EN
    check("byp_x0",     src1_o, 32'hDEAD);
`else
    check("byp_x0",     src1_o, 32'd0);
`endif
    wb_rd = 5'd7; wb_data = 32'h1234; tick();
`ifdef IDEX_WB_BYPASS_EN
    check("byp_rs2",    src2_o, 32'h1234);
`else
    check("byp_rs2",    src2_o, 32'd0);
`endif
    wb_wen = 1'b0; wb_rd = 5'd5; wb_data = 32'hFFFF; tick();
`ifdef IDEX_WB_BYPASS_EN
    check("byp_wen0",   src1_o, 32'hDEAD);
`else
    check("byp_wen0",   src1_o, 32'd0);
`endif
    check("byp_ins",    ins_o, 32'h55);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
